idct_stream_ctrl: RTL
=====================

// Module: idct_stream_ctrl
// PURPOSE
//   Sequencer that wraps the fully pipelined, handshake-free IDCT datapath (64 x WIN in, 64 x WOUT out).
//   Collects a serial valid/ready stream of 64 coefficients into the parallel idct_x register.
//   Launches the block into the pipeline and times its LATENCY-cycle flight.
//   Captures idct_out and re-serialises the 64 samples with valid/ready backpressure.
// PARAMETERS
//   WIN      12  input coefficient width (two's complement)
//   WOUT     9   output sample width (two's complement)
//   N        64  elements per block (8x8)
//   LATENCY  26  IDCT pipeline depth in clk cycles
// PORTS
//   clk        in   1       sole clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       in_data holds a coefficient
//   in_ready   out  1       controller accepts in_data this cycle
//   in_data    in   WIN     coefficient, row-major element order 0..N-1
//   idct_x     out  N*WIN   to IDCT .x; element k at [k*WIN +: WIN]
//   idct_out   in   N*WOUT  from IDCT .out; element k at [k*WOUT +: WOUT]
//   out_valid  out  1       out_data holds a sample
//   out_ready  in   1       downstream accepts out_data this cycle
//   out_data   out  WOUT    sample, element order 0..N-1
//   out_last   out  1       high with element N-1
//   busy       out  1       any block in load, flight or drain
// BEHAVIOUR
//   Reset: in_ready=0, out_valid=0, out_last=0, out_data=0, idct_x=0, busy=0.
//   Both FSMs go to their initial state; counters clear. An in-flight block is discarded (no output).
//   First cycle after reset: in_ready=1.
//   Timing contract: if idct_x is stable during cycle c, idct_out equals IDCT of that block during cycle c+LATENCY.
//   Input FSM:
//     FILL: in_ready=1. A beat transfers when in_valid&in_ready.
//       Word at count i is written to element i of idct_x; i increments.
//       On the beat with i==N-1: i wraps to 0 and the FSM goes to FULL.
//       in_valid gaps only stall; in_data is don't-care when in_valid=0.
//     FULL: in_ready=0; idct_x held constant.
//       If the output FSM is IDLE this cycle, this is the launch cycle: the output FSM goes to WAIT,
//       and the input FSM returns to FILL at the next edge.
//   Output FSM:
//     IDLE: out_valid=0.
//     WAIT: cycle counter runs LATENCY-1..0. The closing edge of launch_cycle+LATENCY captures idct_out
//       into the output buffer; the FSM goes to DRAIN with j=0.
//     DRAIN: out_valid=1, out_data=element j, out_last=(j==N-1).
//       On out_valid&out_ready, j increments; after j==N-1 the FSM returns to IDLE.
//       out_data/out_last are held stable while out_valid&!out_ready.
//   Overlap: the next block may load during WAIT/DRAIN, but it launches only when the output FSM is IDLE.
//     At most one block is in flight or draining.
//     Captured data never sees idct_x modified inside its sample cycle.
//   Arithmetic: no width conversion; data is passed bit-exact. Counters are $clog2(N) and $clog2(LATENCY+1) bits.
//   Simultaneous events: the final DRAIN beat and FULL occurring together do not launch in that cycle.
//     Launch happens the next cycle, when the output FSM reads IDLE.
//   busy = (input count!=0) | input FULL | output FSM!=IDLE.
// TESTING
//   T1 Ramp block in_data=0..63 back-to-back, out_ready=1 -> in_ready low exactly in cycle 64 only.
//      out_valid first high 91 cycles after first accept.
//      Samples 173,-63,42,-19,22,-5,12,4,-176,52... last 0; out_last only on the 64th.
//   T2 Same block, out_ready toggling 1010..., in_valid with random gaps -> identical 64-value sequence.
//      No drops or duplicates; out_data stable on stalled cycles.
//   T3 Two blocks streamed back-to-back, out_ready=1 -> block 2 fills during block 1 WAIT.
//      Block 2 launches on the first IDLE cycle; both outputs match the reference model.
//   T4 Assert rst for 1 cycle during WAIT (10 cycles after launch) -> no out_valid afterwards.
//      A fresh ramp then reproduces T1 timing and values exactly.
//   T5 out_ready=0 held for 200 cycles during DRAIN with the next block fully loaded.
//      -> in_ready stays 0; no launch; out_data frozen on element 0; resumes correctly.
//   T6 All-zero block -> 64 zeros; busy drops to 0 the cycle after the last beat.

Source files
------------

// File: rtl/idct_stream_ctrl.sv
// Stream wrapper around a handshake-free, fixed-latency IDCT pipeline: gathers a serial
// block into idct_x, times its flight, captures idct_out and replays it with backpressure.
//
// Input FSM                            Output FSM
//   state   | meaning                    state   | meaning
//   IN_FILL | accepting coefficients     OUT_IDLE  | nothing in flight
//   IN_FULL | block held, awaiting launch OUT_WAIT  | block in pipeline, latency countdown
//                                        OUT_DRAIN | replaying captured samples
module idct_stream_ctrl #(
    parameter int WIN     = 12,
    parameter int WOUT    = 9,
    parameter int N       = 64,
    parameter int LATENCY = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIN-1:0]    in_data,
    output logic [N*WIN-1:0]  idct_x,
    input  logic [N*WOUT-1:0] idct_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WOUT-1:0]   out_data,
    output logic              out_last,
    output logic              busy
);
    localparam int CW = $clog2(N);
    localparam int LW = $clog2(LATENCY + 1);

    localparam logic [0:0] IN_FILL = 1'b0;
    localparam logic [0:0] IN_FULL = 1'b1;

    localparam logic [1:0] OUT_IDLE  = 2'd0;
    localparam logic [1:0] OUT_WAIT  = 2'd1;
    localparam logic [1:0] OUT_DRAIN = 2'd2;

    logic [0:0]        r_in_state;
    logic [CW-1:0]     r_in_cnt;
    logic [N*WIN-1:0]  r_x;
    logic [1:0]        r_out_state;
    logic [LW-1:0]     r_lat_cnt;
    logic [CW-1:0]     r_out_idx;
    logic [N*WOUT-1:0] r_obuf;

    logic w_in_beat;
    logic w_launch;
    logic w_out_beat;

    assign in_ready   = !rst && (r_in_state == IN_FILL);
    assign w_in_beat  = in_valid && in_ready;
    // Launch only when nothing is in flight or draining, so idct_x is never disturbed mid-sample.
    assign w_launch   = (r_in_state == IN_FULL) && (r_out_state == OUT_IDLE);
    assign out_valid  = (r_out_state == OUT_DRAIN);
    assign w_out_beat = out_valid && out_ready;
    assign out_data   = r_obuf[r_out_idx*WOUT +: WOUT];
    assign out_last   = out_valid && (r_out_idx == CW'(N - 1));
    assign idct_x     = r_x;
    assign busy       = (r_in_cnt != '0) || (r_in_state == IN_FULL) || (r_out_state != OUT_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state <= IN_FILL;
            r_in_cnt   <= '0;
            r_x        <= '0;
        end else begin
            case (r_in_state)
                IN_FILL: begin
                    if (w_in_beat) begin
                        r_x[r_in_cnt*WIN +: WIN] <= in_data;
                        if (r_in_cnt == CW'(N - 1)) begin
                            r_in_cnt   <= '0;
                            r_in_state <= IN_FULL;
                        end else begin
                            r_in_cnt <= r_in_cnt + 1'b1;
                        end
                    end
                end
                IN_FULL: begin
                    if (w_launch) r_in_state <= IN_FILL;
                end
                default: r_in_state <= IN_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_state <= OUT_IDLE;
            r_lat_cnt   <= '0;
            r_out_idx   <= '0;
            r_obuf      <= '0;
        end else begin
            case (r_out_state)
                OUT_IDLE: begin
                    if (w_launch) begin
                        r_out_state <= OUT_WAIT;
                        r_lat_cnt   <= LW'(LATENCY - 1);
                    end
                end
                OUT_WAIT: begin
                    // Count 0 marks the cycle launch+LATENCY, when idct_out holds this block.
                    if (r_lat_cnt == '0) begin
                        r_obuf      <= idct_out;
                        r_out_idx   <= '0;
                        r_out_state <= OUT_DRAIN;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                OUT_DRAIN: begin
                    if (w_out_beat) begin
                        if (r_out_idx == CW'(N - 1)) begin
                            r_out_idx   <= '0;
                            r_out_state <= OUT_IDLE;
                        end else begin
                            r_out_idx <= r_out_idx + 1'b1;
                        end
                    end
                end
                default: r_out_state <= OUT_IDLE;
            endcase
        end
    end
endmodule
